simd_lane_shifter_pipe: RTL and testbench
=========================================

Name: simd_lane_shifter_pipe

Overview:
- Parametrised, pipelined successor of the combinational extraction left shifter in the posit datapath.
- Splits a DATA_W word into 4, 2 or 1 lanes by mode and left-shifts each lane by its own amount plus a fixed bias. The bias strips the regime terminator.
- Reports per-lane sticky (bits lost off the top) and overflow flags.
- Sits between regime-count logic and fraction/exponent alignment, with valid/ready handshakes on both sides so it can be retimed.

Parameters:
- DATA_W, 32, total word width; must be a multiple of 4, minimum 8.
- SH_W, 6, width of each per-lane shift field; must be ≥ clog2(DATA_W)+1.
- BIAS, 1, constant added to every lane shift amount (0 or 1).
- STAGES, 2, pipeline depth; legal values 1 or 2.
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  operand word.
- in_mode  in  2  00 = 4 lanes of DATA_W/4; 01 = 2 lanes of DATA_W/2; 10 = 1 lane; 11 = treated as 10.
- in_shamt  in  4*SH_W  field k is the shift for lane k.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  shifted word.
- out_sticky  out  4  bit k = OR of bits of lane k shifted past its MSB.
- out_ovf  out  4  bit k = effective shift of lane k ≥ lane width.
- out_mode  out  2  mode echoed with the beat.
- out_tag  out  TAG_W  tag echoed with the beat.

Behaviour:
- Lane mapping:
  - Mode 00: lane k = bits [k*Q+Q-1 : k*Q], with Q = DATA_W/4.
  - Mode 01: lane 0 = low half, lane 1 = high half; shamt fields 2 and 3 ignored.
  - Mode 10/11: lane 0 = whole word; fields 1–3 ignored.
  - Unused lane flag bits are driven 0.
- Effective shift: eff_k = shamt_k + BIAS, computed at SH_W+1 bits so it cannot wrap.
- Lane result = (lane << eff_k) truncated to lane width, zero-filled from the LSB. Bits never cross a lane boundary.
- If eff_k ≥ lane width: lane result = 0, out_ovf[k] = 1, out_sticky[k] = OR of the entire lane.
- Otherwise out_sticky[k] = OR of the top eff_k bits of the input lane.
- Pipeline split:
  - STAGES=2: stage 1 applies the coarse shift (eff bits ≥ 3, multiples of 8) and registers the partial sticky. Stage 2 applies the fine shift (eff[2:0]) and finalises sticky/ovf.
  - STAGES=1: a single registered stage.
  - Latency is STAGES cycles from the in_valid&&in_ready edge to out_valid, with no stalls.
- Handshake:
  - Each stage holds valid plus payload. A stage loads when it is empty or its contents are leaving the same cycle.
  - in_ready = !stage1_valid || stage1_advances. This is combinational from out_ready through the chain, with no skid buffer.
  - Full throughput: 1 beat/cycle while out_ready=1.
  - When out_ready=0 with the pipe full: in_ready=0, and all payloads hold stable. out_data must not change while out_valid && !out_ready.
  - Simultaneous accept and emit in the same cycle is legal and loses no beat.
  - Bubbles collapse: an empty stage 2 accepts from stage 1 even when out_ready=0.
- Mode, tag and data for one beat always travel together; a mode change between consecutive beats needs no bubble.
- Reset (async assert, sync deassert expected upstream):
  - All stage valids = 0, out_valid = 0, out_data = 0, out_sticky = 0, out_ovf = 0, out_mode = 0, out_tag = 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards all in-flight beats; nothing is emitted after release until new input.
- Payload registers need reset only to give defined outputs; they load only on an accept.

Test Plan:
- DATA_W=32, BIAS=1, mode 00, in_data=0x81_40_FF_01, shamt = {0,1,2,3} (lane3..0) -> out_data=0x02_00_F8_10; out_sticky=4'b1110; out_ovf=0; out_valid 2 cycles after accept.
- Mode 01, in_data=0x0001_8000, shamt lane0=0, lane1=14 -> out_data=0x8000_0000 (high lane 0x0001<<15); low lane 0x8000<<1=0; out_sticky=4'b0001; out_ovf=0.
- Mode 10, in_data=0xFFFF_FFFF, shamt0=31 -> eff=32: out_data=0, out_ovf=4'b0001, out_sticky=4'b0001. Mode 11 with the same stimulus gives the identical result.
- Back-to-back 8 beats with out_ready=1 and alternating modes -> 8 outputs on 8 consecutive cycles, in order, each tag matching its input.
- Pipe full and out_ready held 0 for 5 cycles -> in_ready=0, out_data/out_tag stable. On release, beats drain in order with none lost or duplicated.
- rst_n pulsed low while 2 beats are in flight -> out_valid=0 immediately (async), all outputs 0, and no stale beat appears after release.

Source files
------------

// File: rtl/simd_lane_shifter_pipe_if.sv
// ---------------------------------------------------------------------------
// simd_lane_shifter_pipe_if
// Handshake and payload bundle for the pipelined SIMD lane shifter.
//   in_valid / in_ready   : upstream handshake
//   in_data               : operand word (DATA_W)
//   in_mode               : lane split (00 = 4 lanes, 01 = 2 lanes, 1x = 1 lane)
//   in_shamt              : 4 shift fields of SH_W bits, field k for lane k
//   in_tag                : opaque sideband carried with the beat
//   out_valid / out_ready : downstream handshake
//   out_data              : shifted word
//   out_sticky / out_ovf  : per-lane lost-bit and over-shift flags
//   out_mode / out_tag    : mode and tag echoed with the beat
// Modports: master = producer/consumer side (testbench or neighbours),
//           slave  = the shifter itself.
// ---------------------------------------------------------------------------
interface simd_lane_shifter_pipe_if #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 6,
  parameter int TAG_W  = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_mode;
  logic [4*SH_W-1:0]   in_shamt;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [3:0]          out_sticky;
  logic [3:0]          out_ovf;
  logic [1:0]          out_mode;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_ovf, out_mode, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_ovf, out_mode, out_tag
  );
endinterface

// File: rtl/simd_lane_shifter_pipe.sv
// ---------------------------------------------------------------------------
// simd_lane_shifter_pipe
// Splits a DATA_W word into 4, 2 or 1 lanes (by mode) and left-shifts each
// lane by its own amount plus BIAS, zero-filling from the LSB. Bits never
// cross a lane boundary. Per lane it reports sticky (OR of bits pushed past
// the lane MSB) and overflow (effective shift >= lane width).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : simd_lane_shifter_pipe_if.slave (valid/ready in, valid/ready out)
// Pipeline: STAGES=2 does the coarse shift (multiples of 8) in stage 1 and the
// fine shift (eff[2:0]) in stage 2; STAGES=1 does both before one register.
// Any STAGES value other than 1 builds the two-stage pipe.
// ---------------------------------------------------------------------------
module simd_lane_shifter_pipe #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 6,
  parameter int BIAS   = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  simd_lane_shifter_pipe_if.slave bus
);

  localparam int Q = DATA_W / 4;
  localparam int H = DATA_W / 2;

  typedef logic [SH_W:0] amt_t;

  localparam amt_t Q_W = amt_t'(Q);
  localparam amt_t H_W = amt_t'(H);
  localparam amt_t F_W = amt_t'(DATA_W);

  // Shift a lane held in the low w bits of a DATA_W word left by a.
  // Returns {sticky, result}; result is masked back to w bits. Bits shifted
  // past position w-1 feed the sticky bit. An amount >= w clears the lane and
  // reports the whole lane as lost.
  function automatic logic [DATA_W:0] lane_shl(input logic [DATA_W-1:0] lane,
                                               input amt_t w, input amt_t a);
    logic [2*DATA_W-1:0] ext;
    logic [DATA_W-1:0]   mask;
    mask = ~({DATA_W{1'b1}} << w);
    ext  = {{DATA_W{1'b0}}, lane} << a;
    if (a >= w) lane_shl = {|lane, {DATA_W{1'b0}}};
    else        lane_shl = {|(ext >> w), ext[DATA_W-1:0] & mask};
  endfunction

  // Mode 11 behaves exactly like mode 10.
  function automatic logic [1:0] lane_cfg(input logic [1:0] m);
    lane_cfg = (m == 2'b11) ? 2'b10 : m;
  endfunction

  // ---------------------------------------------------------------- coarse
  amt_t            eff        [4];
  amt_t            coarse_amt [4];
  logic [3:0][2:0] c_fine;
  logic [DATA_W:0] cq [4];
  logic [DATA_W:0] ch [2];
  logic [DATA_W:0] cf;
  logic [DATA_W-1:0] c_word;
  logic [3:0]        c_sticky;
  logic [3:0]        c_ovf;

  // eff is one bit wider than the shift field so shamt + BIAS never wraps.
  for (genvar gi = 0; gi < 4; gi++) begin : g_eff
    assign eff[gi]        = {1'b0, bus.in_shamt[gi*SH_W +: SH_W]} + amt_t'(BIAS);
    assign coarse_amt[gi] = eff[gi] & ~amt_t'(7);
    assign c_fine[gi]     = eff[gi][2:0];
    assign cq[gi] = lane_shl(DATA_W'(bus.in_data[gi*Q +: Q]), Q_W, coarse_amt[gi]);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_coarse_half
    assign ch[gi] = lane_shl(DATA_W'(bus.in_data[gi*H +: H]), H_W, coarse_amt[gi]);
  end

  assign cf = lane_shl(bus.in_data, F_W, coarse_amt[0]);

  always_comb begin
    c_word   = '0;
    c_sticky = '0;
    c_ovf    = '0;
    case (lane_cfg(bus.in_mode))
      2'b00: begin
        for (int k = 0; k < 4; k++) begin
          c_word      = c_word | (cq[k][DATA_W-1:0] << (k*Q));
          c_sticky[k] = cq[k][DATA_W];
          c_ovf[k]    = (eff[k] >= Q_W);
        end
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          c_word      = c_word | (ch[k][DATA_W-1:0] << (k*H));
          c_sticky[k] = ch[k][DATA_W];
          c_ovf[k]    = (eff[k] >= H_W);
        end
      end
      default: begin
        c_word      = cf[DATA_W-1:0];
        c_sticky[0] = cf[DATA_W];
        c_ovf[0]    = (eff[0] >= F_W);
      end
    endcase
  end

  // ------------------------------------------------------ stage plumbing
  logic [DATA_W-1:0] f_word;
  logic [3:0]        f_sticky;
  logic [3:0]        f_ovf;
  logic [3:0][2:0]   f_fine;
  logic [1:0]        f_mode;
  logic [TAG_W-1:0]  f_tag;
  logic              src_valid;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [3:0]        out_sticky_reg;
  logic [3:0]        out_ovf_reg;
  logic [1:0]        out_mode_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic              out_load;

  // Output stage loads when empty or when its beat leaves this cycle; an
  // empty output stage therefore pulls from stage 1 even with out_ready low.
  assign out_load = src_valid && (!out_valid_reg || bus.out_ready);

  if (STAGES == 1) begin : g_one
    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign src_valid    = bus.in_valid;
    assign f_word       = c_word;
    assign f_sticky     = c_sticky;
    assign f_ovf        = c_ovf;
    assign f_fine       = c_fine;
    assign f_mode       = bus.in_mode;
    assign f_tag        = bus.in_tag;
  end else begin : g_two
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_word_reg;
    logic [3:0]        s1_sticky_reg;
    logic [3:0]        s1_ovf_reg;
    logic [3:0][2:0]   s1_fine_reg;
    logic [1:0]        s1_mode_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic              accept;

    // Ready ripples combinationally from out_ready; there is no skid buffer.
    assign bus.in_ready = !s1_valid_reg || out_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_reg  <= 1'b0;
        s1_word_reg   <= '0;
        s1_sticky_reg <= '0;
        s1_ovf_reg    <= '0;
        s1_fine_reg   <= '0;
        s1_mode_reg   <= '0;
        s1_tag_reg    <= '0;
      end else begin
        if (accept)        s1_valid_reg <= 1'b1;
        else if (out_load) s1_valid_reg <= 1'b0;
        if (accept) begin
          s1_word_reg   <= c_word;
          s1_sticky_reg <= c_sticky;
          s1_ovf_reg    <= c_ovf;
          s1_fine_reg   <= c_fine;
          s1_mode_reg   <= bus.in_mode;
          s1_tag_reg    <= bus.in_tag;
        end
      end
    end

    assign src_valid = s1_valid_reg;
    assign f_word    = s1_word_reg;
    assign f_sticky  = s1_sticky_reg;
    assign f_ovf     = s1_ovf_reg;
    assign f_fine    = s1_fine_reg;
    assign f_mode    = s1_mode_reg;
    assign f_tag     = s1_tag_reg;
  end

  // ------------------------------------------------------------------ fine
  logic [DATA_W:0]   fq [4];
  logic [DATA_W:0]   fh [2];
  logic [DATA_W:0]   ff;
  logic [DATA_W-1:0] r_word;
  logic [3:0]        r_sticky;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fine_quarter
    assign fq[gi] = lane_shl(DATA_W'(f_word[gi*Q +: Q]), Q_W, amt_t'(f_fine[gi]));
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fine_half
    assign fh[gi] = lane_shl(DATA_W'(f_word[gi*H +: H]), H_W, amt_t'(f_fine[gi]));
  end

  assign ff = lane_shl(f_word, F_W, amt_t'(f_fine[0]));

  // Final sticky = bits lost in the coarse step OR bits lost in the fine step.
  always_comb begin
    r_word   = '0;
    r_sticky = '0;
    case (lane_cfg(f_mode))
      2'b00: begin
        for (int k = 0; k < 4; k++) begin
          r_word      = r_word | (fq[k][DATA_W-1:0] << (k*Q));
          r_sticky[k] = f_sticky[k] | fq[k][DATA_W];
        end
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          r_word      = r_word | (fh[k][DATA_W-1:0] << (k*H));
          r_sticky[k] = f_sticky[k] | fh[k][DATA_W];
        end
      end
      default: begin
        r_word      = ff[DATA_W-1:0];
        r_sticky[0] = f_sticky[0] | ff[DATA_W];
      end
    endcase
  end

  // ---------------------------------------------------------- output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_sticky_reg <= '0;
      out_ovf_reg    <= '0;
      out_mode_reg   <= '0;
      out_tag_reg    <= '0;
    end else begin
      if (out_load)           out_valid_reg <= 1'b1;
      else if (bus.out_ready) out_valid_reg <= 1'b0;
      if (out_load) begin
        out_data_reg   <= r_word;
        out_sticky_reg <= r_sticky;
        out_ovf_reg    <= f_ovf;
        out_mode_reg   <= f_mode;
        out_tag_reg    <= f_tag;
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_sticky = out_sticky_reg;
  assign bus.out_ovf    = out_ovf_reg;
  assign bus.out_mode   = out_mode_reg;
  assign bus.out_tag    = out_tag_reg;

endmodule

// File: tb/tb_simd_lane_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_simd_lane_shifter_pipe
// Self-checking bench for simd_lane_shifter_pipe: directed vector table with
// latency check, back-to-back, stall/drain, async reset and randomized
// traffic scored against a lane-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_simd_lane_shifter_pipe;
  localparam int DW     = 32;
  localparam int SW     = 6;
  localparam int TW     = 4;
  localparam int BIAS   = 1;
  localparam int STAGES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_lane_shifter_pipe_if #(.DATA_W(DW), .SH_W(SW), .TAG_W(TW)) bus ();

  simd_lane_shifter_pipe #(
    .DATA_W(DW), .SH_W(SW), .BIAS(BIAS), .STAGES(STAGES), .TAG_W(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    sticky;
    logic [3:0]    ovf;
    logic [1:0]    mode;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic [1:0]      mode;
    logic [4*SW-1:0] shamt;
    logic [DW-1:0]   e_data;
    logic [3:0]      e_sticky;
    logic [3:0]      e_ovf;
  } vec_t;

  int            n_vec = 0;
  int            n_mis = 0;
  exp_t          sbq[$];
  int            cyc_no = 0;
  int            emit_cnt = 0;
  int            first_emit = 0;
  int            last_emit = 0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data;
  logic [TW-1:0] hold_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: per-lane integer arithmetic on the lane value.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [1:0] m,
                                 input logic [4*SW-1:0] sh, input logic [TW-1:0] t);
    exp_t e;
    int nl, w, eff;
    longint unsigned lane, res, mask;
    nl   = (m == 2'b00) ? 4 : (m == 2'b01) ? 2 : 1;
    w    = DW / nl;
    mask = (64'd1 << w) - 64'd1;
    e.data = '0; e.sticky = '0; e.ovf = '0; e.mode = m; e.tag = t;
    for (int k = 0; k < nl; k++) begin
      lane = (64'(d) >> (k*w)) & mask;
      eff  = int'(sh[k*SW +: SW]) + BIAS;
      if (eff >= w) begin
        e.ovf[k]    = 1'b1;
        e.sticky[k] = (lane != 0);
      end else begin
        res         = (lane << eff) & mask;
        e.sticky[k] = ((lane >> (w - eff)) != 0);
        e.data      = e.data | DW'(res << (k*w));
      end
    end
    return e;
  endfunction

  // One clock of traffic: drive at negedge, observe 2 ns later (before the
  // next rising edge), score emitted beats, record accepted beats.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                      input logic [4*SW-1:0] sh, input logic [TW-1:0] t,
                      input logic r, output logic acc);
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.in_mode = m;
    bus.in_shamt = sh; bus.in_tag = t; bus.out_ready = r;
    cyc_no++;
    #2;
    if (hold_pending) begin
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_data", 64'(bus.out_data), 64'(hold_data));
      chk("stall_tag", 64'(bus.out_tag), 64'(hold_tag));
    end
    if (bus.out_valid && r) begin
      if (sbq.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL spurious_beat: got tag 0x%0h data 0x%0h expected no beat",
                 bus.out_tag, bus.out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_data", 64'(bus.out_data), 64'(e.data));
        chk("sb_sticky", 64'(bus.out_sticky), 64'(e.sticky));
        chk("sb_ovf", 64'(bus.out_ovf), 64'(e.ovf));
        chk("sb_mode", 64'(bus.out_mode), 64'(e.mode));
        chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
      end
      if (emit_cnt == 0) first_emit = cyc_no;
      last_emit = cyc_no;
      emit_cnt++;
    end
    acc = v && bus.in_ready;
    if (acc) sbq.push_back(model(d, m, sh, t));
    hold_pending = bus.out_valid && !r;
    hold_data    = bus.out_data;
    hold_tag     = bus.out_tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t            tbl [12];
    logic            acc;
    int              cyc;
    logic [DW-1:0]   pd;
    logic [1:0]      pm;
    logic [4*SW-1:0] ps;
    logic [TW-1:0]   pt;

    tbl[0]  = '{32'h8140FF01, 2'b00, {6'd0, 6'd1, 6'd2, 6'd3},    32'h0200F810, 4'b1110, 4'b0000};
    tbl[1]  = '{32'h00018000, 2'b01, {6'd63, 6'd5, 6'd14, 6'd0},  32'h80000000, 4'b0001, 4'b0000};
    tbl[2]  = '{32'hFFFFFFFF, 2'b10, {6'd3, 6'd3, 6'd3, 6'd31},   32'h00000000, 4'b0001, 4'b0001};
    tbl[3]  = '{32'hFFFFFFFF, 2'b11, {6'd3, 6'd3, 6'd3, 6'd31},   32'h00000000, 4'b0001, 4'b0001};
    tbl[4]  = '{32'h12345678, 2'b00, {4{6'd7}},                   32'h00000000, 4'b1111, 4'b1111};
    tbl[5]  = '{32'hA5A5A5A5, 2'b00, {4{6'd63}},                  32'h00000000, 4'b1111, 4'b1111};
    tbl[6]  = '{32'h00000001, 2'b10, {6'd0, 6'd0, 6'd0, 6'd30},   32'h80000000, 4'b0000, 4'b0000};
    tbl[7]  = '{32'h0000FFFF, 2'b01, {6'd0, 6'd0, 6'd2, 6'd15},   32'h00000000, 4'b0001, 4'b0001};
    tbl[8]  = '{32'h00000000, 2'b00, {4{6'd0}},                   32'h00000000, 4'b0000, 4'b0000};
    tbl[9]  = '{32'h000000F0, 2'b10, {6'd9, 6'd9, 6'd9, 6'd3},    32'h00000F00, 4'b0000, 4'b0000};
    tbl[10] = '{32'h80808080, 2'b00, {4{6'd0}},                   32'h00000000, 4'b1111, 4'b0000};
    tbl[11] = '{32'h01020408, 2'b00, {4{6'd2}},                   32'h08102040, 4'b0000, 4'b0000};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0;
    bus.in_shamt = '0; bus.in_tag = '0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_sticky", 64'(bus.out_sticky), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("rst_out_mode", 64'(bus.out_mode), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed table, one beat at a time, with latency measurement
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = tbl[i].data; bus.in_mode = tbl[i].mode;
      bus.in_shamt = tbl[i].shamt; bus.in_tag = TW'(i); bus.out_ready = 1'b1;
      #2;
      chk("tbl_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      cyc = 0;
      do begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc++;
      end while (!bus.out_valid && cyc < 20);
      #2;
      chk("tbl_latency", 64'(cyc), 64'(STAGES));
      chk("tbl_data", 64'(bus.out_data), 64'(tbl[i].e_data));
      chk("tbl_sticky", 64'(bus.out_sticky), 64'(tbl[i].e_sticky));
      chk("tbl_ovf", 64'(bus.out_ovf), 64'(tbl[i].e_ovf));
      chk("tbl_mode", 64'(bus.out_mode), 64'(tbl[i].mode));
      chk("tbl_tag", 64'(bus.out_tag), 64'(i));
    end
    step(1'b0, '0, 2'b00, '0, '0, 1'b1, acc);

    // Back-to-back: 8 beats, cycling modes, must emerge on 8 consecutive cycles
    emit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, 2'(i % 4), 24'($urandom), TW'(i), 1'b1, acc);
      chk("b2b_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < STAGES + 3; i++) step(1'b0, '0, 2'b00, '0, '0, 1'b1, acc);
    chk("b2b_count", 64'(emit_cnt), 64'd8);
    chk("b2b_span", 64'(last_emit - first_emit), 64'd7);

    // Stall: fill with out_ready low, hold 5 cycles, then drain
    pd = $urandom; pm = 2'($urandom); ps = 24'($urandom); pt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pd, pm, ps, pt, 1'b0, acc);
      if (acc) begin pd = $urandom; pm = 2'($urandom); ps = 24'($urandom); pt = pt + 4'd1; end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pd, pm, ps, pt, 1'b0, acc);
      chk("stall_in_ready", 64'(acc), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pd, pm, ps, pt, 1'b1, acc);
      if (acc) begin pd = $urandom; pm = 2'($urandom); ps = 24'($urandom); pt = pt + 4'd1; end
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 2'b00, '0, '0, 1'b1, acc);
    chk("stall_drain_empty", 64'(sbq.size()), 64'd0);

    // Async reset with two beats in flight
    step(1'b1, 32'h0F0F0F0F, 2'b00, 24'h0, 4'hA, 1'b1, acc);
    step(1'b1, 32'hF0F0F0F0, 2'b01, 24'h0, 4'hB, 1'b1, acc);
    @(posedge clk);
    #3;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_out_sticky", 64'(bus.out_sticky), 64'd0);
    chk("arst_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("arst_out_mode", 64'(bus.out_mode), 64'd0);
    chk("arst_out_tag", 64'(bus.out_tag), 64'd0);
    sbq.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 2'b00, '0, '0, 1'b1, acc);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);

    // Randomized traffic with random backpressure
    pd = $urandom; pm = 2'($urandom); ps = 24'($urandom); pt = 4'd0;
    for (int i = 0; i < 400; i++) begin
      logic v, r;
      v = ($urandom % 10) < 7;
      r = ($urandom % 10) < 6;
      step(v, pd, pm, ps, pt, r, acc);
      if (acc) begin
        pd = $urandom;
        pm = 2'($urandom);
        // Bias half the beats toward small shifts so results are not all zero.
        ps = ($urandom % 2) ? 24'($urandom) : 24'($urandom & 32'h00_71C71C7);
        pt = pt + 4'd1;
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 2'b00, '0, '0, 1'b1, acc);
    chk("rand_drain_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
